// File: rtl/button_conditioner.sv
// Eight-channel button conditioner: synchronise, debounce, detect presses and
// generate auto-repeat movement strobes with opposing-direction suppression.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 'd500000,
   parameter int unsigned REPEAT_CYCLES   = 'd200000,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] btn_raw,
   output logic [7:0] btn_level,
   output logic [7:0] btn_press,
   output logic [7:0] btn_move
);

   localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);
   localparam logic [19:0] REP_LAST = 20'(REPEAT_CYCLES - 1);

   logic [7:0]  raw_pol;
   logic [7:0]  sync_meta;
   logic [7:0]  sync;
   logic [7:0]  level;
   logic [7:0]  level_nxt;
   logic [7:0]  press;
   logic [7:0]  conflict;
   logic [7:0]  run;
   logic [19:0] db_cnt [8];
   logic [19:0] db_nxt [8];
   logic [19:0] rc     [8];
   logic [19:0] rc_nxt [8];

   // Polarity is fixed before the synchroniser so its reset value of 0 is
   // always the released level.
   assign raw_pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

   always_comb begin
      level_nxt = level;
      for (int i = 0; i < 8; i++) begin
         db_nxt[i] = '0;
         if (sync[i] != level[i]) begin
            if (db_cnt[i] == DEB_LAST) begin
               level_nxt[i] = ~level[i];
            end else begin
               db_nxt[i] = db_cnt[i] + 20'd1;
            end
         end
      end
   end

   always_comb begin
      conflict = '0;
      for (int p = 0; p < 4; p++) begin
         conflict[2*p]   = level[2*p] & level[2*p+1];
         conflict[2*p+1] = level[2*p] & level[2*p+1];
      end
   end

   assign run = level & ~conflict;

   // Repeat phase is held at zero while idle or conflicted, so the first
   // unconflicted held cycle always strobes.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         rc_nxt[i] = '0;
         if (run[i] && (rc[i] != REP_LAST)) begin
            rc_nxt[i] = rc[i] + 20'd1;
         end
      end
   end

   always_comb begin
      btn_move = '0;
      for (int i = 0; i < 8; i++) begin
         btn_move[i] = run[i] & (rc[i] == 20'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync      <= '0;
         level     <= '0;
         press     <= '0;
         for (int i = 0; i < 8; i++) begin
            db_cnt[i] <= '0;
            rc[i]     <= '0;
         end
      end else begin
         sync_meta <= raw_pol;
         sync      <= sync_meta;
         level     <= level_nxt;
         press     <= level_nxt & ~level;
         for (int i = 0; i < 8; i++) begin
            db_cnt[i] <= db_nxt[i];
            rc[i]     <= rc_nxt[i];
         end
      end
   end

   assign btn_level = level;
   assign btn_press = press;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random per-channel
// stimulus, checked against a behavioural model of the button rules.
module tb_button_conditioner;

   localparam int DEB = 4;
   localparam int REP = 5;

   logic       clk;
   logic       rst_n;
   logic [7:0] btn_raw;
   logic [7:0] btn_level;
   logic [7:0] btn_press;
   logic [7:0] btn_move;

   int nvec;
   int nerr;

   // model state
   logic [7:0] m_d1, m_d2;
   logic [7:0] m_level, m_press, m_move, m_was;
   int         m_run [8];
   int         m_age [8];

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES  (REP),
      .ACTIVE_LOW     (1'b0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_move (btn_move)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0;
      m_level = '0; m_press = '0; m_move = '0; m_was = '0;
      for (int i = 0; i < 8; i++) begin
         m_run[i] = 0;
         m_age[i] = 0;
      end
   endtask

   // A raw value is seen by the debouncer two edges after it is sampled; a
   // level flips once it has disagreed for DEB consecutive edges.
   task automatic model_edge(input logic [7:0] r);
      logic [7:0] seen, old_level;
      logic       conf, act;
      seen = m_d2; m_d2 = m_d1; m_d1 = r;
      old_level = m_level;
      for (int i = 0; i < 8; i++) begin
         if (seen[i] != old_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_level[i] = ~old_level[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_press = m_level & ~old_level;
      for (int i = 0; i < 8; i++) begin
         conf = m_level[i] & m_level[i ^ 1];
         act  = m_level[i] & ~conf;
         if (act) m_age[i] = m_was[i] ? m_age[i] + 1 : 0;
         m_was[i]  = act;
         m_move[i] = act && ((m_age[i] % REP) == 0);
      end
   endtask

   task automatic step(input logic [7:0] r);
      btn_raw = r;
      @(posedge clk);
      model_edge(r);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      btn_raw = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if ({btn_level, btn_press, btn_move} !== 24'h0) begin
         nerr++;
         $display("FAIL reset: got lvl=%h prs=%h mov=%h, expected all 00", btn_level, btn_press, btn_move);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_bounce();
      for (int k = 0; k < 16; k++) begin
         step((k < 3) ? 8'h01 : 8'h00);
         nvec++;
         if ({btn_level, btn_press, btn_move} !== {m_level, m_press, m_move} ||
             {btn_level, btn_press, btn_move} !== 24'h0) begin
            nerr++;
            $display("FAIL bounce step %0d: got lvl=%h prs=%h mov=%h, expected all 00", k, btn_level, btn_press, btn_move);
         end
      end
   endtask

   task automatic test_hold_release();
      int rise_step, fall_step, presses, moves, post_press;
      rise_step = -1; fall_step = -1; presses = 0; moves = 0; post_press = 0;
      for (int k = 1; k <= 34; k++) begin
         step((k <= 20) ? 8'h10 : 8'h00);
         nvec++;
         if ({btn_level, btn_press, btn_move} !== {m_level, m_press, m_move}) begin
            nerr++;
            $display("FAIL hold step %0d: got lvl=%h prs=%h mov=%h, expected lvl=%h prs=%h mov=%h",
                     k, btn_level, btn_press, btn_move, m_level, m_press, m_move);
         end
         if (btn_level[4] && rise_step < 0) rise_step = k;
         if (!btn_level[4] && rise_step >= 0 && fall_step < 0) fall_step = k;
         if (btn_press[4]) presses++;
         if (btn_press[4] && k > 20) post_press++;
         if (btn_move[4]) moves++;
      end
      nvec++;
      if (rise_step != 6 || fall_step != 26) begin
         nerr++;
         $display("FAIL hold_timing: got rise=%0d fall=%0d, expected rise=6 fall=26", rise_step, fall_step);
      end
      nvec++;
      if (presses != 1 || post_press != 0 || moves != 4) begin
         nerr++;
         $display("FAIL hold_counts: got press=%0d release_press=%0d move=%0d, expected 1 0 4", presses, post_press, moves);
      end
   endtask

   task automatic test_conflict();
      int press03, bad_move, first_free, first_move, moves0;
      press03 = 0; bad_move = 0; first_free = -1; first_move = -1; moves0 = 0;
      for (int k = 1; k <= 12; k++) begin
         step(8'h03);
         nvec++;
         if ({btn_level, btn_press, btn_move} !== {m_level, m_press, m_move}) begin
            nerr++;
            $display("FAIL conflict step %0d: got lvl=%h prs=%h mov=%h, expected lvl=%h prs=%h mov=%h",
                     k, btn_level, btn_press, btn_move, m_level, m_press, m_move);
         end
         if (btn_press == 8'h03) press03++;
         if (btn_move[1:0] != 2'b00) bad_move++;
      end
      nvec++;
      if (press03 != 1 || bad_move != 0) begin
         nerr++;
         $display("FAIL conflict_summary: got press03=%0d moves=%0d, expected 1 0", press03, bad_move);
      end
      for (int k = 1; k <= 18; k++) begin
         step(8'h01);
         nvec++;
         if ({btn_level, btn_press, btn_move} !== {m_level, m_press, m_move}) begin
            nerr++;
            $display("FAIL recover step %0d: got lvl=%h prs=%h mov=%h, expected lvl=%h prs=%h mov=%h",
                     k, btn_level, btn_press, btn_move, m_level, m_press, m_move);
         end
         if (!btn_level[1] && first_free < 0) first_free = k;
         if (btn_move[0] && first_move < 0) first_move = k;
         if (btn_move[0]) moves0++;
      end
      // level[1] falls at step 6; strobes at steps 6, 11, 16
      nvec++;
      if (first_free != 6 || first_move != 6 || moves0 != 3) begin
         nerr++;
         $display("FAIL recover_summary: got free=%0d first_move=%0d moves=%0d, expected 6 6 3", first_free, first_move, moves0);
      end
      for (int k = 0; k < 8; k++) step(8'h00);
   endtask

   task automatic test_reset_mid_hold();
      int waited, rise_step, presses;
      waited = 0;
      while (btn_level != 8'h20 && waited < 20) begin
         step(8'h20);
         waited++;
      end
      nvec++;
      if (btn_level !== 8'h20) begin
         nerr++;
         $display("FAIL midhold_setup: got lvl=%h, expected 20", btn_level);
      end
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({btn_level, btn_press, btn_move} !== 24'h0) begin
         nerr++;
         $display("FAIL midhold_async: got lvl=%h prs=%h mov=%h, expected all 00", btn_level, btn_press, btn_move);
      end
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      rise_step = -1; presses = 0;
      for (int k = 1; k <= 12; k++) begin
         step(8'h20);
         nvec++;
         if ({btn_level, btn_press, btn_move} !== {m_level, m_press, m_move}) begin
            nerr++;
            $display("FAIL midhold step %0d: got lvl=%h prs=%h mov=%h, expected lvl=%h prs=%h mov=%h",
                     k, btn_level, btn_press, btn_move, m_level, m_press, m_move);
         end
         if (btn_level[5] && rise_step < 0) rise_step = k;
         if (btn_press[5]) presses++;
      end
      nvec++;
      if (rise_step != 6 || presses != 1) begin
         nerr++;
         $display("FAIL midhold_summary: got rise=%0d press=%0d, expected 6 1", rise_step, presses);
      end
      for (int k = 0; k < 8; k++) step(8'h00);
   endtask

   task automatic test_random();
      logic [7:0] r;
      int         hold [8];
      r = '0;
      for (int i = 0; i < 8; i++) hold[i] = 0;
      for (int k = 0; k < 800; k++) begin
         for (int i = 0; i < 8; i++) begin
            if (hold[i] == 0) begin
               r[i] = $urandom_range(0, 1);
               hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 25);
            end
            hold[i]--;
         end
         step(r);
         nvec++;
         if ({btn_level, btn_press, btn_move} !== {m_level, m_press, m_move}) begin
            nerr++;
            $display("FAIL random step %0d: raw=%h got lvl=%h prs=%h mov=%h, expected lvl=%h prs=%h mov=%h",
                     k, r, btn_level, btn_press, btn_move, m_level, m_press, m_move);
         end
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      btn_raw = 8'h00;
      rst_n = 1'b0;
      #2;
      test_reset();
      test_bounce();
      test_hold_release();
      test_conflict();
      test_reset_mid_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
